// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported instruction/data memory between the IF stage and the
// MEM stage. Each cycle the pipeline may ask for a fetch and/or a load/store.
// These are serialised onto a registered req/ack memory bus, with the data
// access first because it belongs to the older instruction. The whole pipeline
// is stalled until every access requested in the current cycle has completed.
// A watchdog aborts an access whose ack never arrives and records that in a
// sticky error flag.
//
// Parameters:
//   TIMEOUT    cycles to wait for ram_ack before aborting (0 disables)
//   TO_W       watchdog counter width, 2**TO_W > TIMEOUT
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_req, if_addr            fetch request and PC
//   mem_rd, mem_wr             MEM-stage load / store (both high = store)
//   mem_addr, mem_wdata        load/store address and store data
//   ram_req, ram_we            registered memory request and write enable
//   ram_addr, ram_wdata        registered memory address and write data
//   ram_rdata, ram_ack         memory read data and completion
//   if_rdata, mem_rdata        fetched instruction and load result
//   stall                      freeze PC and all pipeline registers
//   bus_err                    sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic [31:0] if_rdata,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic            TO_EN   = (TIMEOUT != 0);
    // Count value on which the next ack-less edge brings the count to TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? {TO_W{1'b0}} : TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              d_done_q, d_done_d;
    logic              i_done_q, i_done_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;

    logic              dpend;
    logic              ipend;
    logic              acc_busy;
    logic              timeout;
    logic              done_now;
    logic [31:0]       rdata_eff;

    assign dpend     = (mem_rd | mem_wr) & ~d_done_q;
    assign ipend     = if_req & ~i_done_q;
    assign stall     = dpend | ipend;
    assign acc_busy  = (state_q != IDLE);
    // A real ack on the same edge beats the watchdog.
    assign timeout   = TO_EN & acc_busy & ~ram_ack & (cnt_q == TO_LAST);
    assign done_now  = ram_ack | timeout;
    assign rdata_eff = timeout ? 32'h0000_0000 : ram_rdata;

    // Next-state, bus request and result-latch logic.
    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        d_done_d    = d_done_q;
        i_done_d    = i_done_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q | timeout;

        // The pipeline advances on any unstalled edge, opening a new window.
        if (!stall) begin
            d_done_d = 1'b0;
            i_done_d = 1'b0;
        end else begin
            d_done_d = d_done_q;
            i_done_d = i_done_q;
        end

        case (state_q)
            IDLE: begin
                if (dpend) begin
                    state_d     = DACC;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_wr;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    cnt_d       = {TO_W{1'b0}};
                end else if (ipend) begin
                    state_d    = IACC;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = if_addr;
                    cnt_d      = {TO_W{1'b0}};
                end else begin
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                end
            end
            DACC: begin
                if (done_now) begin
                    d_done_d = 1'b1;
                    // A store leaves the previous load result untouched.
                    if (!ram_we_q) begin
                        mem_rdata_d = rdata_eff;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                    // Chain straight into the fetch without dropping ram_req.
                    if (ipend) begin
                        state_d    = IACC;
                        ram_req_d  = 1'b1;
                        ram_we_d   = 1'b0;
                        ram_addr_d = if_addr;
                        cnt_d      = {TO_W{1'b0}};
                    end else begin
                        state_d   = IDLE;
                        ram_req_d = 1'b0;
                        ram_we_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + TO_W'(1'b1);
                end
            end
            IACC: begin
                if (done_now) begin
                    if_rdata_d = rdata_eff;
                    i_done_d   = 1'b1;
                    state_d    = IDLE;
                    ram_req_d  = 1'b0;
                    ram_we_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1'b1);
                end
            end
            default: begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
                ram_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops ram_req without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'h0000_0000;
            ram_wdata_q <= 32'h0000_0000;
            if_rdata_q  <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
            d_done_q    <= 1'b0;
            i_done_q    <= 1'b0;
            cnt_q       <= {TO_W{1'b0}};
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            d_done_q    <= d_done_d;
            i_done_q    <= i_done_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. The bench plays the memory itself by
// driving ram_ack/ram_rdata cycle by cycle. Inputs change and registered
// outputs are sampled on the falling clock edge; stall is sampled 1 time unit
// after the inputs change.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        bus_err;

    int n_total;
    int n_bad;

    mem_port_arbiter #(
        .TIMEOUT (15),
        .TO_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .if_rdata  (if_rdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ram_ack = 1'b0;
    endtask

    // Hard stop in case the sequence ever stops advancing.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        if_addr   = 32'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        ram_rdata = 32'h0;
        idle_inputs();

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_val("rst_req",      32'(ram_req), 32'd0);
        check_val("rst_we",       32'(ram_we), 32'd0);
        check_val("rst_addr",     ram_addr, 32'h0);
        check_val("rst_wdata",    ram_wdata, 32'h0);
        check_val("rst_if_rdata", if_rdata, 32'h0);
        check_val("rst_mem_rdata",mem_rdata, 32'h0);
        check_val("rst_bus_err",  32'(bus_err), 32'd0);
        check_val("rst_stall",    32'(stall), 32'd0);
        rst = 1'b0;

        // ---------------- fetch only, zero wait ----------------
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1 check_val("t1_stall_c0", 32'(stall), 32'd1);
        @(negedge clk);
        check_val("t1_req",  32'(ram_req), 32'd1);
        check_val("t1_addr", ram_addr, 32'h10);
        check_val("t1_we",   32'(ram_we), 32'd0);
        ram_ack = 1'b1; ram_rdata = 32'h2002000A;
        #1 check_val("t1_stall_c1", 32'(stall), 32'd1);
        @(negedge clk);
        check_val("t1_if_rdata", if_rdata, 32'h2002000A);
        check_val("t1_req_drop", 32'(ram_req), 32'd0);
        check_val("t1_stall_c2", 32'(stall), 32'd0);
        ram_ack = 1'b0;
        @(negedge clk);
        check_val("t1_if_hold", if_rdata, 32'h2002000A);
        idle_inputs();

        // ---------------- load plus fetch, zero wait ----------------
        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 32'h40; if_req = 1'b1; if_addr = 32'h14;
        #1 check_val("t2_stall_c0", 32'(stall), 32'd1);
        @(negedge clk);
        check_val("t2_req_d",  32'(ram_req), 32'd1);
        check_val("t2_addr_d", ram_addr, 32'h40);
        check_val("t2_we_d",   32'(ram_we), 32'd0);
        ram_ack = 1'b1; ram_rdata = 32'h11112222;
        #1 check_val("t2_stall_c1", 32'(stall), 32'd1);
        @(negedge clk);
        check_val("t2_mem_rdata", mem_rdata, 32'h11112222);
        check_val("t2_req_i",     32'(ram_req), 32'd1);
        check_val("t2_addr_i",    ram_addr, 32'h14);
        ram_ack = 1'b1; ram_rdata = 32'h33334444;
        #1 check_val("t2_stall_c2", 32'(stall), 32'd1);
        @(negedge clk);
        check_val("t2_if_rdata", if_rdata, 32'h33334444);
        check_val("t2_req_drop", 32'(ram_req), 32'd0);
        check_val("t2_stall_c3", 32'(stall), 32'd0);
        ram_ack = 1'b0;
        @(negedge clk);
        idle_inputs();

        // ---------------- store with two wait states, then fetch ----------------
        @(negedge clk);
        mem_wr = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h18;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t3_req",   32'(ram_req), 32'd1);
            check_val("t3_we",    32'(ram_we), 32'd1);
            check_val("t3_addr",  ram_addr, 32'h80);
            check_val("t3_wdata", ram_wdata, 32'hDEADBEEF);
            check_val("t3_stall", 32'(stall), 32'd1);
            ram_ack   = (i == 2);
            ram_rdata = 32'h55555555;
        end
        @(negedge clk);
        check_val("t3_mem_rdata_kept", mem_rdata, 32'h11112222);
        check_val("t3_addr_i", ram_addr, 32'h18);
        check_val("t3_we_i",   32'(ram_we), 32'd0);
        check_val("t3_req_i",  32'(ram_req), 32'd1);
        ram_ack = 1'b1; ram_rdata = 32'h0000AAAA;
        @(negedge clk);
        check_val("t3_if_rdata", if_rdata, 32'h0000AAAA);
        check_val("t3_stall_end", 32'(stall), 32'd0);
        check_val("t3_req_drop", 32'(ram_req), 32'd0);
        ram_ack = 1'b0;
        @(negedge clk);
        idle_inputs();

        // ---------------- watchdog abort on a load ----------------
        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 32'h100; ram_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_val("t4_req_wait", 32'(ram_req), 32'd1);
            check_val("t4_err_wait", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        check_val("t4_req_drop",  32'(ram_req), 32'd0);
        check_val("t4_mem_rdata", mem_rdata, 32'h0);
        check_val("t4_bus_err",   32'(bus_err), 32'd1);
        check_val("t4_stall",     32'(stall), 32'd0);
        @(negedge clk);
        idle_inputs();
        check_val("t4_err_sticky1", 32'(bus_err), 32'd1);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1C;
        @(negedge clk);
        check_val("t4_fetch_addr", ram_addr, 32'h1C);
        ram_ack = 1'b1; ram_rdata = 32'h00001234;
        @(negedge clk);
        check_val("t4_fetch_data", if_rdata, 32'h00001234);
        check_val("t4_err_sticky2", 32'(bus_err), 32'd1);
        ram_ack = 1'b0;
        @(negedge clk);
        idle_inputs();

        // ---------------- reset mid-DACC with wait states outstanding ----------------
        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 32'h200; if_req = 1'b1; if_addr = 32'h20;
        ram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check_val("t5_req", 32'(ram_req), 32'd1);
        check_val("t5_addr", ram_addr, 32'h200);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("t5_req_async", 32'(ram_req), 32'd0);
        check_val("t5_we",        32'(ram_we), 32'd0);
        check_val("t5_addr_rst",  ram_addr, 32'h0);
        check_val("t5_wdata_rst", ram_wdata, 32'h0);
        check_val("t5_if_rdata",  if_rdata, 32'h0);
        check_val("t5_mem_rdata", mem_rdata, 32'h0);
        check_val("t5_bus_err",   32'(bus_err), 32'd0);
        check_val("t5_stall_inputs", 32'(stall), 32'd1);
        idle_inputs();
        #1 check_val("t5_stall_idle", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h24;
        @(negedge clk);
        check_val("t5_new_req",  32'(ram_req), 32'd1);
        check_val("t5_new_addr", ram_addr, 32'h24);
        ram_ack = 1'b1; ram_rdata = 32'h00000077;
        @(negedge clk);
        check_val("t5_new_data", if_rdata, 32'h00000077);
        check_val("t5_new_drop", 32'(ram_req), 32'd0);
        ram_ack = 1'b0;
        @(negedge clk);
        idle_inputs();

        // ---------------- ack on the same edge the count hits TIMEOUT ----------------
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h28; ram_rdata = 32'h00000099;
        repeat (14) @(negedge clk);
        @(negedge clk);
        check_val("t6_req_last", 32'(ram_req), 32'd1);
        ram_ack = 1'b1;
        @(negedge clk);
        check_val("t6_if_rdata", if_rdata, 32'h00000099);
        check_val("t6_bus_err",  32'(bus_err), 32'd0);
        check_val("t6_req_drop", 32'(ram_req), 32'd0);
        ram_ack = 1'b0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
